pmu_sample_buf: RTL and testbench

PMU_SAMPLE_BUF -- requirements
Module: pmu_sample_buf

---
 rtl/pmu_sample_buf.sv | 163 ++++++++++++++++
 tb/tb_pmu_sample_buf.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_sample_buf.sv
// PMU sample buffer: circular FIFO for sensor words plus a small control FSM that
// requests a downstream packet once a configured number of words has accumulated.
module pmu_sample_buf #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 10,
    parameter int unsigned PMU_TEST_NUM_DW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              sens_data,
    input  logic                       sens_vld,
    input  logic [PMU_TEST_NUM_DW-1:0] cfg_data_num,
    output logic                       packet_start,
    input  logic                       packet_done,
    input  logic                       pl_rd_en,
    output logic [DW-1:0]              pl_rd_data,
    output logic                       pl_rd_data_vld,
    output logic [AW:0]                fifo_level,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       cfg_err
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStart,
        StBusy
    } state_e;

    logic [DW-1:0]              mem [DEPTH];
    logic [AW-1:0]              wptr_q, wptr_d;
    logic [AW-1:0]              rptr_q, rptr_d;
    logic [AW:0]                level_q, level_d;
    logic [DW-1:0]              rd_data_q, rd_data_d;
    logic                       rd_vld_q;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    logic [PMU_TEST_NUM_DW-1:0] target_q, target_d;
    state_e                     state_q, state_d;

    logic full;
    logic empty;
    logic rd_accept;
    logic wr_accept;
    logic fill_reached;

    // Level never exceeds DEPTH, so its top bit alone marks the full condition.
    assign full  = level_q[AW];
    assign empty = (level_q == '0);

    assign rd_accept = pl_rd_en && !empty;
    assign wr_accept = sens_vld && (!full || rd_accept);

    assign cfg_err      = (cfg_data_num == '0) || (32'(cfg_data_num) > DEPTH);
    assign fill_reached = (32'(level_q) >= 32'(target_q));

    // Datapath next-state.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_accept) begin
            rptr_d    = rptr_q + AW'(1);
            rd_data_d = mem[rptr_q];
        end

        if (wr_accept && !rd_accept) begin
            level_d = level_q + (AW + 1)'(1);
        end else if (!wr_accept && rd_accept) begin
            level_d = level_q - (AW + 1)'(1);
        end

        if (sens_vld && !wr_accept) begin
            overflow_d = 1'b1;
        end
        if (pl_rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control FSM next-state; the packet length is captured on every entry into fill.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;

        unique case (state_q)
            StIdle: begin
                if (!cfg_err) begin
                    state_d  = StFill;
                    target_d = cfg_data_num;
                end
            end
            StFill: begin
                if (cfg_err) begin
                    state_d = StIdle;
                end else if (fill_reached) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StBusy;
            end
            StBusy: begin
                if (packet_done) begin
                    state_d  = StFill;
                    target_d = cfg_data_num;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            target_q    <= '0;
            state_q     <= StIdle;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_accept;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            target_q    <= target_d;
            state_q     <= state_d;
        end
    end

    // Storage is deliberately left without reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wptr_q] <= sens_data;
        end
    end

    assign packet_start   = (state_q == StStart);
    assign pl_rd_data     = rd_data_q;
    assign pl_rd_data_vld = rd_vld_q;
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_pmu_sample_buf.sv
// Bench for pmu_sample_buf: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_pmu_sample_buf;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NW    = 16;
    localparam int DEPTH = 16;

    localparam int PIdle  = 0;
    localparam int PFill  = 1;
    localparam int PStart = 2;
    localparam int PBusy  = 3;

    logic          clk;
    logic          rst;
    logic [DW-1:0] sens_data;
    logic          sens_vld;
    logic [NW-1:0] cfg_data_num;
    logic          packet_start;
    logic          packet_done;
    logic          pl_rd_en;
    logic [DW-1:0] pl_rd_data;
    logic          pl_rd_data_vld;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic          underflow;
    logic          cfg_err;

    pmu_sample_buf #(
        .DW              (DW),
        .AW              (AW),
        .PMU_TEST_NUM_DW (NW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sens_data      (sens_data),
        .sens_vld       (sens_vld),
        .cfg_data_num   (cfg_data_num),
        .packet_start   (packet_start),
        .packet_done    (packet_done),
        .pl_rd_en       (pl_rd_en),
        .pl_rd_data     (pl_rd_data),
        .pl_rd_data_vld (pl_rd_data_vld),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .underflow      (underflow),
        .cfg_err        (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [DW-1:0] mq[$];
    int            m_phase;
    int            m_target;
    logic          m_vld;
    logic [DW-1:0] m_data;
    logic          m_ovf;
    logic          m_unf;

    int checks = 0;
    int errors = 0;
    int ps_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_cfg_err(input int n);
        return (n == 0) || (n > DEPTH);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_phase  = PIdle;
        m_target = 0;
        m_vld    = 1'b0;
        m_data   = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endfunction

    // Advance the model by one rising edge using the inputs present before it.
    function automatic void model_update();
        int lvl;
        bit rd_ok;
        bit wr_ok;
        bit cerr;
        if (!rst) begin
            model_reset();
            return;
        end
        lvl   = mq.size();
        cerr  = exp_cfg_err(int'(cfg_data_num));
        rd_ok = pl_rd_en && (lvl > 0);
        wr_ok = sens_vld && ((lvl < DEPTH) || rd_ok);
        if (sens_vld && !wr_ok) m_ovf = 1'b1;
        if (pl_rd_en && lvl == 0) m_unf = 1'b1;

        case (m_phase)
            PIdle: if (!cerr) begin
                m_phase  = PFill;
                m_target = int'(cfg_data_num);
            end
            PFill: begin
                if (cerr) m_phase = PIdle;
                else if (lvl >= m_target) m_phase = PStart;
            end
            PStart: m_phase = PBusy;
            default: if (packet_done) begin
                m_phase  = PFill;
                m_target = int'(cfg_data_num);
            end
        endcase

        m_vld = rd_ok;
        if (rd_ok) m_data = mq.pop_front();
        if (wr_ok) mq.push_back(sens_data);
    endfunction

    task automatic compare();
        chk("level", 64'(fifo_level), 64'(mq.size()));
        chk("rd_vld", 64'(pl_rd_data_vld), 64'(m_vld));
        chk("rd_data", 64'(pl_rd_data), 64'(m_data));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("cfg_err", 64'(cfg_err), 64'(exp_cfg_err(int'(cfg_data_num))));
        chk("packet_start", 64'(packet_start), 64'(m_phase == PStart));
        if (packet_start === 1'b1) ps_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        sens_vld  = 1'b1;
        sens_data = d;
        step();
        sens_vld  = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        sens_data    = '0;
        sens_vld     = 1'b0;
        cfg_data_num = '0;
        packet_done  = 1'b0;
        pl_rd_en     = 1'b0;
        model_reset();

        // Reset state.
        step();
        step();
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_start", 64'(packet_start), 64'd0);
        chk("rst_rd_data", 64'(pl_rd_data), 64'd0);
        rst = 1'b1;

        // Eight words, one packet, in-order reads one cycle after each request.
        cfg_data_num = 16'd8;
        step();
        ps_cnt = 0;
        for (int i = 1; i <= 8; i++) write_word(DW'(i));
        chk("pkt8_no_early_start", 64'(ps_cnt), 64'd0);
        step();
        chk("pkt8_start_high", 64'(packet_start), 64'd1);
        step();
        chk("pkt8_start_low", 64'(packet_start), 64'd0);
        step();
        chk("pkt8_one_pulse", 64'(ps_cnt), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            pl_rd_en = 1'b1;
            step();
            chk("pkt8_rd_vld", 64'(pl_rd_data_vld), 64'd1);
            chk("pkt8_rd_data", 64'(pl_rd_data), 64'(i));
        end
        pl_rd_en = 1'b0;
        step();
        chk("hold_vld", 64'(pl_rd_data_vld), 64'd0);
        chk("hold_data", 64'(pl_rd_data), 64'd8);
        packet_done = 1'b1;
        step();
        packet_done = 1'b0;

        // Read of an empty buffer.
        pl_rd_en = 1'b1;
        step();
        pl_rd_en = 1'b0;
        chk("empty_rd_vld", 64'(pl_rd_data_vld), 64'd0);
        chk("empty_underflow", 64'(underflow), 64'd1);
        chk("empty_level", 64'(fifo_level), 64'd0);

        // Seventeen writes into a 16-deep buffer.
        do_reset();
        for (int i = 1; i <= 17; i++) write_word(DW'(i));
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            pl_rd_en = 1'b1;
            step();
            chk("ovf_rd_data", 64'(pl_rd_data), 64'(i));
        end
        pl_rd_en = 1'b0;
        step();
        chk("ovf_drained", 64'(fifo_level), 64'd0);

        // Full buffer, simultaneous read and write across pointer wrap.
        do_reset();
        for (int i = 0; i < 16; i++) write_word(DW'(100 + i));
        for (int i = 0; i < 40; i++) begin
            sens_vld  = 1'b1;
            sens_data = DW'(200 + i);
            pl_rd_en  = 1'b1;
            step();
            chk("wrap_level", 64'(fifo_level), 64'd16);
            chk("wrap_rd_data", 64'(pl_rd_data), (i < 16) ? 64'(100 + i) : 64'(200 + i - 16));
        end
        sens_vld = 1'b0;
        pl_rd_en = 1'b0;
        step();
        chk("wrap_no_ovf", 64'(overflow), 64'd0);

        // Invalid configurations, then a valid one.
        do_reset();
        cfg_data_num = 16'd0;
        ps_cnt = 0;
        repeat (3) step();
        chk("cfg0_err", 64'(cfg_err), 64'd1);
        cfg_data_num = 16'(DEPTH + 1);
        repeat (3) step();
        chk("cfg17_err", 64'(cfg_err), 64'd1);
        for (int i = 0; i < 3; i++) write_word(DW'(300 + i));
        repeat (2) step();
        chk("cfg_bad_no_start", 64'(ps_cnt), 64'd0);
        cfg_data_num = 16'd4;
        repeat (2) step();
        chk("cfg4_err_low", 64'(cfg_err), 64'd0);
        chk("cfg4_wait", 64'(ps_cnt), 64'd0);
        write_word(DW'(303));
        repeat (3) step();
        chk("cfg4_start", 64'(ps_cnt), 64'd1);

        // Asynchronous reset while busy with five words stored.
        do_reset();
        cfg_data_num = 16'd5;
        step();
        ps_cnt = 0;
        for (int i = 0; i < 5; i++) write_word(DW'(400 + i));
        repeat (3) step();
        chk("busy_level", 64'(fifo_level), 64'd5);
        chk("busy_started", 64'(ps_cnt), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_level", 64'(fifo_level), 64'd0);
        chk("arst_start", 64'(packet_start), 64'd0);
        chk("arst_vld", 64'(pl_rd_data_vld), 64'd0);
        model_reset();
        step();
        rst = 1'b1;
        ps_cnt = 0;
        step();
        for (int i = 0; i < 4; i++) write_word(DW'(500 + i));
        repeat (2) step();
        chk("arst_no_early_start", 64'(ps_cnt), 64'd0);
        write_word(DW'(504));
        repeat (2) step();
        chk("arst_new_start", 64'(ps_cnt), 64'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            sens_vld    = ($urandom_range(0, 99) < 55);
            sens_data   = $urandom;
            pl_rd_en    = ($urandom_range(0, 99) < 50);
            packet_done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) cfg_data_num = 16'($urandom_range(0, DEPTH + 2));
            rst = ($urandom_range(0, 499) != 0);
            step();
        end
        rst         = 1'b1;
        sens_vld    = 1'b0;
        pl_rd_en    = 1'b0;
        packet_done = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
